// File: rtl/soc_io_pkg.sv
// rtl/soc_io_pkg.sv - register map, STATUS/CTRL bit positions and TX FSM states for the IO-page UART
package soc_io_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_BUSY      = 1;
    localparam int ST_RX_NONEMPTY  = 2;
    localparam int ST_RX_OVERRUN   = 3;
    localparam int ST_TX_DROP      = 4;
    localparam int ST_RX_COUNT_LSB = 8;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_LAUNCH  = 2'd1,
        TX_WAIT_HI = 2'd2,
        TX_WAIT_LO = 2'd3
    } tx_state_e;

    // A 16-deep RX FIFO can report 16, which does not fit the 4-bit STATUS field.
    function automatic logic [3:0] sat_count4(input logic [4:0] count);
        return (count > 5'd15) ? 4'hf : count[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - read-first synchronous FIFO; head is visible combinationally, push+pop allowed when full
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A pop on an empty FIFO is ignored; a pop frees the slot a same-cycle push needs.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_mmio_responder.sv
// rtl/uart_mmio_responder.sv - IO-page UART slave: register decode, read mux, sticky flags, TX pacing FSM
// Optional RX interrupt output and CTRL.irq_en bit when UART_IRQ_EN is defined.
module uart_mmio_responder
    import soc_io_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic [1:0]  reg_addr,
    input  logic        mem_rstrb,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    input  logic        tx_active,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    output logic        irq
);

    logic        wr_en, rd_en, data_wr, ctrl_wr, ctrl_clear;
    logic        tx_pop, tx_full, tx_empty, tx_busy;
    logic [7:0]  tx_head;
    logic [$clog2(TX_DEPTH):0] unused_tx_count;
    logic        rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_head;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic [4:0]  rx_count_ext;
    logic        rx_overrun_q, rx_overrun_d;
    logic        tx_drop_q, tx_drop_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] status_w;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_dv_w;
    logic        irq_en;
    logic        unused_wdata;
    tx_state_e   state_q, state_d;

    assign wr_en      = sel && (mem_wmask != 4'b0000);
    assign rd_en      = sel && mem_rstrb;
    assign data_wr    = wr_en && (reg_addr == REG_DATA) && mem_wmask[0];
    assign ctrl_wr    = wr_en && (reg_addr == REG_CTRL) && mem_wmask[0];
    assign ctrl_clear = ctrl_wr && mem_wdata[CTRL_CLEAR];
    assign rx_pop     = rd_en && (reg_addr == REG_DATA) && !rx_empty;
    assign unused_wdata = ^{mem_wdata[31:8], mem_wdata[CTRL_IRQ_EN]};

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (data_wr),
        .push_data_i (mem_wdata[7:0]),
        .pop_i       (tx_pop),
        .pop_data_o  (tx_head),
        .full_o      (tx_full),
        .empty_o     (tx_empty),
        .count_o     (unused_tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (rx_dv),
        .push_data_i (rx_byte),
        .pop_i       (rx_pop),
        .pop_data_o  (rx_head),
        .full_o      (rx_full),
        .empty_o     (rx_empty),
        .count_o     (rx_count)
    );

    // TX pacing: a byte is only launched once uart_tx has gone idle, and the next one
    // waits until tx_active has been seen high and then low again.
    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        tx_pop    = 1'b0;
        tx_dv_w   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!tx_empty && !tx_active) begin
                    tx_pop    = 1'b1;
                    tx_byte_d = tx_head;
                    state_d   = TX_LAUNCH;
                end
            end
            TX_LAUNCH: begin
                tx_dv_w = 1'b1;
                state_d = TX_WAIT_HI;
            end
            TX_WAIT_HI: begin
                if (tx_active) begin
                    state_d = TX_WAIT_LO;
                end
            end
            TX_WAIT_LO: begin
                if (!tx_active) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign tx_busy = !tx_empty || (state_q != TX_IDLE);

    // A new drop/overrun event in the same cycle as a clear is kept rather than lost.
    always_comb begin
        rx_overrun_d = rx_overrun_q;
        tx_drop_d    = tx_drop_q;
        if (ctrl_clear) begin
            rx_overrun_d = 1'b0;
            tx_drop_d    = 1'b0;
        end
        if (rx_dv && rx_full && !rx_pop) begin
            rx_overrun_d = 1'b1;
        end
        if (data_wr && tx_full && !tx_pop) begin
            tx_drop_d = 1'b1;
        end
    end

    assign rx_count_ext = 5'(rx_count);

    always_comb begin
        status_w                             = '0;
        status_w[ST_TX_FULL]                 = tx_full;
        status_w[ST_TX_BUSY]                 = tx_busy;
        status_w[ST_RX_NONEMPTY]             = !rx_empty;
        status_w[ST_RX_OVERRUN]              = rx_overrun_q;
        status_w[ST_TX_DROP]                 = tx_drop_q;
        status_w[ST_RX_COUNT_LSB +: 4]       = sat_count4(rx_count_ext);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (reg_addr)
                REG_DATA:   rdata_d = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
                REG_STATUS: rdata_d = status_w;
                REG_CTRL:   rdata_d = {30'd0, irq_en, 1'b0};
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= TX_IDLE;
            tx_byte_q    <= 8'd0;
            rdata_q      <= 32'd0;
            rx_overrun_q <= 1'b0;
            tx_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_byte_q    <= tx_byte_d;
            rdata_q      <= rdata_d;
            rx_overrun_q <= rx_overrun_d;
            tx_drop_q    <= tx_drop_d;
        end
    end

`ifdef UART_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (ctrl_wr) begin
            irq_en_d = mem_wdata[CTRL_IRQ_EN];
        end
        irq_d = irq_en_q && (!rx_empty || rx_overrun_q);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    assign mem_rdata = rdata_q;
    assign tx_dv     = tx_dv_w;
    assign tx_byte   = tx_byte_q;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// tb/tb_uart_mmio_responder.sv - self-checking bench: queue-based register/FIFO model plus directed vectors
module tb_uart_mmio_responder;

    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  reg_addr = 2'd0;
    logic        mem_rstrb = 1'b0;
    logic [3:0]  mem_wmask = 4'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        irq;

    always #5 clk = ~clk;

    uart_mmio_responder #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .sel       (sel),
        .reg_addr  (reg_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_active (tx_active),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .irq       (irq)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_dv  = 0;

    // uart_tx stand-in: busy for 3 cycles after each start pulse, or forced busy.
    bit tx_stuck = 1'b0;
    int emu_cnt  = 0;
    assign tx_active = tx_stuck || (emu_cnt != 0);

    logic [7:0]  rx_m[$];
    logic [7:0]  tx_m[$];
    bit          ovr_m = 0, drop_m = 0, irq_en_m = 0;
    bit          inflight = 0, seen_hi = 0, started = 0;
    logic [7:0]  launched = 8'd0;
    logic [31:0] exp_rdata = 32'd0;
    bit          exp_irq = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: registers as queues and sticky bits, updated once per clock from the bus inputs.
    initial begin
        forever begin
            @(posedge clk);
            started = 1;
            if (!resetn) begin
                rx_m.delete();
                tx_m.delete();
                ovr_m = 0; drop_m = 0; irq_en_m = 0;
                exp_rdata = 32'd0;
                exp_irq = 0;
            end else begin
                bit nxt_irq;
                int cnt;
                nxt_irq = irq_en_m && (rx_m.size() != 0 || ovr_m);
                if (sel && mem_rstrb) begin
                    case (reg_addr)
                        2'd0: exp_rdata = (rx_m.size() != 0) ? {23'd0, 1'b1, rx_m.pop_front()} : 32'd0;
                        2'd1: begin
                            cnt = (rx_m.size() > 15) ? 15 : rx_m.size();
                            exp_rdata = (cnt << 8) | (drop_m << 4) | (ovr_m << 3)
                                      | ((rx_m.size() != 0) << 2)
                                      | (((tx_m.size() != 0) || inflight) << 1)
                                      | (tx_m.size() >= TX_DEPTH);
                        end
                        2'd2: exp_rdata = {30'd0, irq_en_m, 1'b0};
                        default: exp_rdata = 32'd0;
                    endcase
                end
                if (sel && mem_wmask[0]) begin
                    if (reg_addr == 2'd0) begin
                        if (tx_m.size() < TX_DEPTH) tx_m.push_back(mem_wdata[7:0]);
                        else drop_m = 1;
                    end else if (reg_addr == 2'd2) begin
                        if (mem_wdata[0]) begin
                            ovr_m = 0;
                            drop_m = 0;
                        end
`ifdef UART_IRQ_EN
                        irq_en_m = mem_wdata[1];
`endif
                    end
                end
                if (rx_dv) begin
                    if (rx_m.size() < RX_DEPTH) rx_m.push_back(rx_byte);
                    else ovr_m = 1;
                end
                exp_irq = nxt_irq;
            end
        end
    end

    // Compare process: every cycle for rdata/irq, plus TX launch ordering and handshake rules.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("rdata", mem_rdata, exp_rdata);
                check("irq", {31'd0, irq}, {31'd0, exp_irq});
            end
            if (!resetn) begin
                inflight = 0; seen_hi = 0; emu_cnt = 0;
            end else begin
                if (tx_dv === 1'b1) begin
                    n_dv++;
                    check("tx_dv_before_tx_active_fell", {31'd0, inflight}, 32'd0);
                    check("tx_dv_with_nothing_queued", {31'd0, (tx_m.size() == 0)}, 32'd0);
                    if (tx_m.size() != 0) begin
                        launched = tx_m.pop_front();
                        check("tx_byte", {24'd0, tx_byte}, {24'd0, launched});
                    end
                    inflight = 1;
                    seen_hi = 0;
                end else if (inflight) begin
                    check("tx_byte_hold", {24'd0, tx_byte}, {24'd0, launched});
                    if (tx_active) seen_hi = 1;
                    else if (seen_hi) inflight = 0;
                end
                if (tx_dv === 1'b1) emu_cnt = 3;
                else if (emu_cnt > 0) emu_cnt--;
            end
        end
    end

    // Bus tasks are entered at a negedge and return at the next one, so calls chain back-to-back.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; reg_addr = a; mem_wmask = 4'hf; mem_wdata = d;
        @(negedge clk);
        sel = 1'b0; mem_wmask = 4'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; reg_addr = a; mem_rstrb = 1'b1;
        @(negedge clk);
        sel = 1'b0; mem_rstrb = 1'b0;
        d = mem_rdata;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 300; i++) begin
            if (tx_m.size() == 0 && !inflight && !tx_active) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        check("tx_drain_done", {31'd0, done}, 32'd1);
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int dv0;
        idle(4);
        resetn = 1'b1;

        check("reset_rdata", mem_rdata, 32'd0);
        bus_read(2'd1, rd);
        check("t1_status_after_reset", rd, 32'h0000_0000);
        idle(3);
        check("t1_no_tx_dv", n_dv, 32'd0);

        dv0 = n_dv;
        bus_write(2'd0, 32'h41);
        bus_write(2'd0, 32'h42);
        wait_tx_drain();
        check("t2_two_pulses", n_dv - dv0, 32'd2);
        bus_read(2'd1, rd);
        check("t2_status_idle", rd, 32'h0000_0000);

        tx_stuck = 1'b1;
        idle(1);
        dv0 = n_dv;
        for (int i = 1; i <= 5; i++) bus_write(2'd0, 32'(i));
        idle(2);
        check("t3_no_pulse_while_busy", n_dv - dv0, 32'd0);
        bus_read(2'd1, rd);
        check("t3_status_full_drop", rd, 32'h0000_0013);
        tx_stuck = 1'b0;
        wait_tx_drain();
        check("t3_four_pulses", n_dv - dv0, 32'd4);
        bus_read(2'd1, rd);
        check("t3_drop_sticky", rd, 32'h0000_0010);
        bus_write(2'd2, 32'h1);
        bus_read(2'd1, rd);
        check("t3_drop_cleared", rd, 32'h0000_0000);

        for (int i = 0; i < 9; i++) rx_push(8'(8'h10 + i));
        bus_read(2'd1, rd);
        check("t4_status_full_overrun", rd, 32'h0000_080C);
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd0, rd);
            check("t4_data", rd, 32'(32'h110 + i));
        end
        bus_read(2'd0, rd);
        check("t4_data_empty", rd, 32'h0000_0000);
        bus_write(2'd3, 32'hffff_ffff);
        bus_read(2'd3, rd);
        check("t4_reserved", rd, 32'h0000_0000);
        bus_write(2'd2, 32'h1);

        for (int i = 0; i < 8; i++) rx_push(8'(8'h10 + i));
        rx_dv = 1'b1; rx_byte = 8'h55;
        bus_read(2'd0, rd);
        rx_dv = 1'b0;
        check("t5_pop_push_full", rd, 32'h0000_0110);
        bus_read(2'd1, rd);
        check("t5_status_no_overrun", rd, 32'h0000_0804);
        for (int i = 1; i < 8; i++) begin
            bus_read(2'd0, rd);
            check("t5_data", rd, 32'(32'h110 + i));
        end
        bus_read(2'd0, rd);
        check("t5_last_pop", rd, 32'h0000_0155);

        rx_dv = 1'b1; rx_byte = 8'h77;
        bus_read(2'd0, rd);
        rx_dv = 1'b0;
        check("t5_pop_push_empty", rd, 32'h0000_0000);
        bus_read(2'd0, rd);
        check("t5_stored_after_empty_pop", rd, 32'h0000_0177);

        bus_write(2'd2, 32'h2);
        bus_read(2'd2, rd);
`ifdef UART_IRQ_EN
        check("t6_ctrl_irq_en", rd, 32'h0000_0002);
`else
        check("t6_ctrl_irq_en", rd, 32'h0000_0000);
`endif
        rx_push(8'h33);
        check("t6_irq_lag", {31'd0, irq}, 32'd0);
        idle(1);
`ifdef UART_IRQ_EN
        check("t6_irq_set", {31'd0, irq}, 32'd1);
`else
        check("t6_irq_set", {31'd0, irq}, 32'd0);
`endif
        bus_read(2'd0, rd);
        check("t6_data", rd, 32'h0000_0133);
        idle(1);
        check("t6_irq_clear", {31'd0, irq}, 32'd0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
